mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter for the single unified instruction/data memory port. It shares that port between the multicycle core (requester 0: instruction fetch and load/store) and a loader/debug requester (requester 1). Arbitration is round-robin with optional locked bursts bounded by a maximum beat count. The block sits between the core's memory-address/data muxing and the memory, and returns read data with one-cycle latency.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive granted beats under lock (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset; sampled on posedge clk
- r0_req / r1_req  in  1  requester n wants a beat this cycle
- r0_lock / r1_lock  in  1  keep ownership after this beat; qualified by req
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  ADDR_W  beat address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_gnt / r1_gnt  out  1  beat accepted this cycle (combinational)
- r0_rvalid / r1_rvalid  out  1  read data valid (registered)
- r0_rdata / r1_rdata  out  DATA_W  read data; 0 when rvalid is low
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address
- owner  out  2  current lock owner: 0 none, 1 req0, 2 req1 (registered)

## Operation
- State is held in `owner_q` ∈ {OWN_NONE, OWN_R0, OWN_R1}, together with `prio_q` (the requester favoured on a tie) and `beat_q` (counts from 0 to MAX_BURST).
- Grant selection each cycle:
  - If `owner_q` = OWN_Rn and rn_req=1, grant n.
  - If `owner_q` = OWN_Rn and rn_req=0, ownership is dropped and selection falls through to the round-robin rule below in the same cycle.
  - Otherwise, if exactly one requester is asserting req, grant it.
  - If both are asserting req, grant `prio_q`.
- At most one gnt is high per cycle. gnt is never high without the matching req.
- Memory mux:
  - The granted requester's addr and wdata drive the memory port, and mem_we = its we.
  - With no grant: mem_we=0, and mem_addr/mem_wdata hold their last driven values. The registered copies reset to 0.
- After a granted beat from requester n:
  - lock=1 and beat_q+1 < MAX_BURST: `owner_q` ← OWN_Rn and beat_q increments.
  - Otherwise: `owner_q` ← OWN_NONE, beat_q ← 0, and `prio_q` ← the other requester (fairness).
- A forced release at MAX_BURST sets `prio_q` to the other requester even if lock stays high. If the other side is idle, the same requester may re-acquire the port on the next cycle.
- Read return: rn_rvalid is registered as gnt_n & ~we_n, and rn_rdata = mem_rdata while rn_rvalid=1.
- Writes produce no rvalid.

## Timing
- Reset (reset=0 at posedge) forces:
  - owner = 0, `prio_q` = R0, beat_q = 0
  - all rvalid = 0
  - registered mem_addr/mem_wdata = 0
- gnt and mem_we are combinational from req and state, so they are 0 whenever both req inputs are 0.
- Reset asserted in the cycle after a granted read: rvalid is suppressed and that data is lost. The requester must reissue the read.
- Latency: a read granted in cycle t gives rvalid/rdata in cycle t+1. Throughput is one beat per cycle.
- Back-to-back beats to different requesters are legal. Each rvalid is routed to the requester granted in the previous cycle.
- A requester must hold req, addr, we and wdata stable until gnt is seen high.
- lock without req is ignored.

## Structure
- The shared types package holds:
  - `arb_owner_t` enum (OWN_NONE=2'd0, OWN_R0=2'd1, OWN_R1=2'd2)
  - `ARB_R0`/`ARB_R1` requester-index constants
- One sub-module, `rr_pick2`: a combinational two-way round-robin picker taking (req0, req1, prio) and returning gnt0 and gnt1.
- All state lives in `mem_arbiter`.

## Test plan
- Reset then idle: reset=0 for 2 cycles, then no requests → owner=0, both gnt=0, mem_we=0, rvalid=0.
- Single read: r0 reads addr 0x10 with mem_rdata=0xDEADBEEF → r0_gnt=1 in cycle t; r0_rvalid=1 and r0_rdata=0xDEADBEEF in t+1; r1_rvalid=0.
- Contention: both request continuously without lock → grants alternate R0, R1, R0, R1 starting from R0 after reset.
- Locked burst cap: MAX_BURST=4, r0 holds lock=1 and req=1 while r1 requests → r0 is granted 4 consecutive beats, then r1 is granted; owner goes 1 → 1 → 1 → 0 → 0.
- Early unlock: r0 lock=1 for 2 beats, then lock=0 on the 3rd → ownership releases after beat 3 and r1 is granted on the next cycle.
- Reset mid-read: r1 read granted at t, reset=0 at t+1 → r1_rvalid=0 at t+1, owner=0, and the next r1 request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg: shared owner/requester types for the arbiter. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } arb_owner_t;

  localparam logic ARB_R0 = 1'b0;
  localparam logic ARB_R1 = 1'b1;

  function automatic arb_owner_t owner_of(input logic idx);
    return (idx == ARB_R1) ? OWN_R1 : OWN_R0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// +----------------------------------------------------------------------+
// | rr_pick2: two-way combinational round-robin picker.         Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  output logic o_gnt0,
  output logic o_gnt1
);

  assign o_gnt0 = i_req0 & (~i_req1 | (i_prio == ARB_R0));
  assign o_gnt1 = i_req1 & (~i_req0 | (i_prio == ARB_R1));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter with bounded locked bursts. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_lock,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_lock,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int                    c_beat_w   = $clog2(MAX_BURST + 1);
  localparam logic [c_beat_w-1:0]   c_beat_max = c_beat_w'(MAX_BURST);

  arb_owner_t          r_owner, w_owner_nxt;
  logic                r_prio, w_prio_nxt;
  logic [c_beat_w-1:0] r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_rvalid0, r_rvalid1;

  logic                w_hold0, w_hold1;
  logic                w_rr_gnt0, w_rr_gnt1;
  logic                w_gnt0, w_gnt1, w_gnt_any;
  logic                w_sel, w_lock;
  logic [c_beat_w-1:0] w_beat_cur, w_beat_inc;

  // An owner keeps the port only while it still requests; otherwise fall through to round-robin.
  assign w_hold0 = (r_owner == OWN_R0) & r0_req;
  assign w_hold1 = (r_owner == OWN_R1) & r1_req;

  rr_pick2 u_pick (
    .i_req0 (r0_req),
    .i_req1 (r1_req),
    .i_prio (r_prio),
    .o_gnt0 (w_rr_gnt0),
    .o_gnt1 (w_rr_gnt1)
  );

  assign w_gnt0    = w_hold0 | (~w_hold1 & w_rr_gnt0);
  assign w_gnt1    = w_hold1 | (~w_hold0 & w_rr_gnt1);
  assign w_gnt_any = w_gnt0 | w_gnt1;
  assign w_sel     = w_gnt1 ? ARB_R1 : ARB_R0;
  assign w_lock    = w_gnt1 ? r1_lock : r0_lock;
  // A fresh winner starts its burst count from zero even if the other side held a count.
  assign w_beat_cur = (r_owner == owner_of(w_sel)) ? r_beat : '0;
  assign w_beat_inc = w_beat_cur + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner     <= OWN_NONE;
      r_prio      <= ARB_R0;
      r_beat      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_prio      <= w_prio_nxt;
      r_beat      <= w_beat_nxt;
      r_mem_addr  <= mem_addr;
      r_mem_wdata <= mem_wdata;
      r_rvalid0   <= w_gnt0 & ~r0_we;
      r_rvalid1   <= w_gnt1 & ~r1_we;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_beat_nxt  = r_beat;
    if (((r_owner == OWN_R0) & ~r0_req) | ((r_owner == OWN_R1) & ~r1_req)) begin
      w_owner_nxt = OWN_NONE;
      w_beat_nxt  = '0;
    end
    if (w_gnt_any) begin
      if (w_lock && (w_beat_inc < c_beat_max)) begin
        w_owner_nxt = owner_of(w_sel);
        w_beat_nxt  = w_beat_inc;
      end else begin
        w_owner_nxt = OWN_NONE;
        w_beat_nxt  = '0;
        w_prio_nxt  = ~w_sel;
      end
    end
  end

  always_comb begin
    r0_gnt    = w_gnt0;
    r1_gnt    = w_gnt1;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_we    = 1'b0;
    if (w_gnt0) begin
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
      mem_we    = r0_we;
    end else if (w_gnt1) begin
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
      mem_we    = r1_we;
    end
  end

  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = r_rvalid0 ? mem_rdata : '0;
  assign r1_rdata  = r_rvalid1 ? mem_rdata : '0;
  assign owner     = r_owner;

endmodule

`default_nettype wire
